hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the EX forwarding logic.
- Produces per-stage register load enables and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles four cases: load-use hazards that forwarding cannot cover, instruction/data memory wait states, and EX-resolved control redirects, including discarding a wrong-path fetch still outstanding when a redirect occurs.
- Keeps saturating performance counters for stall and flush events.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
id_rs1  in  5  rs1 field of instruction in ID
id_rs2  in  5  rs2 field of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_is_load  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
ex_redirect  in  1  EX resolved taken branch/jal/jalr; held while EX is frozen
imem_req  in  1  fetch outstanding this cycle
imem_resp  in  1  fetch data valid this cycle
dmem_req  in  1  MEM-stage load/store outstanding
dmem_resp  in  1  data memory access completes this cycle
load_pc  out  1  PC register enable
load_if_id  out  1  IF/ID enable
load_id_ex  out  1  ID/EX enable
load_ex_mem  out  1  EX/MEM enable
load_mem_wb  out  1  MEM/WB enable
flush_if_id  out  1  IF/ID loads NOP (qualified by load_if_id)
flush_id_ex  out  1  ID/EX loads NOP (qualified by load_id_ex)
discarding  out  1  state == DISCARD
stall_cnt  out  CNT_W  cycles with load_pc == 0
flush_cnt  out  CNT_W  redirects taken
lu_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- States: RUN, DISCARD. Reset (rst low, asynchronous) sets state RUN and all counters 0.
- While rst is low, all load_* = 0 and all flush_* = 0.
- Defaults: all load_* = 1, flush_* = 0.
- Cases are evaluated each cycle in strict priority order, highest first.

1. DMEM freeze (dmem_req & !dmem_resp):
- All load_* = 0, flushes 0, no state change.
- ex_redirect and load-use are ignored and re-evaluated after the freeze ends.
- The cycle with dmem_resp = 1 is a normal cycle under the rules below.

2. DISCARD state:
- load_pc = 0, load_if_id = 0, flush_id_ex = 1; EX/MEM and MEM/WB run.
- On imem_resp = 1, the returned (wrong-path) data is not captured and the next state is RUN.
- A new ex_redirect in DISCARD cannot occur (ID/EX holds a bubble) and is ignored.

3. Redirect (ex_redirect in RUN):
- load_pc = 1 (target), flush_if_id = 1, flush_id_ex = 1.
- flush_cnt increments.
- If imem_req & !imem_resp in the same cycle, the next state is DISCARD; otherwise stay in RUN.
- Redirect beats load-use and fetch wait.

4. Fetch wait (imem_req & !imem_resp in RUN):
- load_pc = 0, load_if_id = 0, flush_id_ex = 1 (bubble downstream).

5. Load-use: condition is ex_is_load & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- load_pc = 0, load_if_id = 0, flush_id_ex = 1; exactly one bubble.
- Next cycle the load is in MEM and forwarding covers it.
- lu_cnt increments.

Counters:
- stall_cnt increments on every cycle with rst high and load_pc == 0.
- All counters saturate at all-ones and never wrap.
- Counters and state are registered; all enables and flushes are combinational from state and inputs (zero latency).

Test Plan:
- Load-use: lw x5 in EX, ID add x6,x5,x7 (uses_rs1, rs1 = 5) -> one cycle load_pc = 0, load_if_id = 0, flush_id_ex = 1, lu_cnt 0->1; next cycle all enables 1. Repeat with ex_rd = 0 -> no stall.
- DMEM miss: dmem_req = 1, dmem_resp = 0 for 4 cycles while a load-use condition holds -> all load_* = 0 for 4 cycles, lu_cnt unchanged, stall_cnt = 4. On the dmem_resp cycle the load-use bubble is inserted and lu_cnt = 1.
- Redirect with fetch complete: ex_redirect = 1, imem_req = 1, imem_resp = 1 -> load_pc = 1, flush_if_id = flush_id_ex = 1, flush_cnt = 1, state stays RUN.
- Redirect with outstanding fetch: ex_redirect = 1, imem_req = 1, imem_resp = 0, then imem_resp after 3 cycles -> discarding = 1 for 3 cycles with load_if_id = 0 and flush_id_ex = 1. The cycle after imem_resp, state is RUN and the target fetch proceeds.
- Reset mid-DISCARD: drop rst while discarding = 1 -> immediately all enables 0, counters 0. After release, state is RUN with all enables 1.
- Saturation: preload stall_cnt to 2^CNT_W - 2 (via CNT_W = 4 build, 14 stall cycles), then stall 3 more cycles -> stall_cnt = 15 and holds.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: per-stage load/flush enables for a 5-stage core,
// wrong-path fetch discard after redirects, and saturating stall/flush/load-use counters.
module hazard_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             discarding,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    logic dmem_freeze;
    logic imem_wait;
    logic load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign dmem_freeze = dmem_req & ~dmem_resp;
    assign imem_wait   = imem_req & ~imem_resp;
    assign load_use    = ex_is_load & (ex_rd != 5'd0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                          (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (!rst) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (dmem_freeze) begin
            // Whole pipe holds; redirect and load-use get re-evaluated once memory returns
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (state_q == DISCARD) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
            if (imem_resp) state_d = RUN;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
            // The in-flight fetch is wrong-path; swallow its response before refetching
            if (imem_wait) state_d = DISCARD;
        end else if (imem_wait) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
            lu_cnt_d    = sat_inc(lu_cnt_q);
        end

        if (rst && !load_pc) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign discarding = (state_q == DISCARD);
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign lu_cnt     = lu_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a cycle-level model of the
// controller's priority rules, built with 4-bit counters so saturation is reachable.
module tb_hazard_stall_ctrl;
    localparam int TCW  = 4;
    localparam int CMAX = (1 << TCW) - 1;

    logic           clk, rst;
    logic [4:0]     id_rs1, id_rs2, ex_rd;
    logic           id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;
    logic           imem_req, imem_resp, dmem_req, dmem_resp;
    logic           load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic           flush_if_id, flush_id_ex, discarding;
    logic [TCW-1:0] stall_cnt, flush_cnt, lu_cnt;

    int errs, checks;
    int m_stall, m_flush, m_lu;
    bit m_disc;

    hazard_stall_ctrl #(.CNT_W(TCW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .discarding(discarding),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // 0 normal, 1 dmem freeze, 2 discard, 3 redirect, 4 fetch wait, 5 load-use, 6 reset
    function automatic int kind_of();
        bit lu;
        lu = ex_is_load && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (!rst)                        return 6;
        if (dmem_req && !dmem_resp)      return 1;
        if (m_disc)                      return 2;
        if (ex_redirect)                 return 3;
        if (imem_req && !imem_resp)      return 4;
        if (lu)                          return 5;
        return 0;
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
    function automatic logic [6:0] exp_out(input int k);
        logic fe, be;
        fe = (k == 0 || k == 3);
        be = (k != 1 && k != 6);
        return {fe, fe, be, be, be, logic'(k == 3), logic'(k >= 2 && k <= 5)};
    endfunction

    task automatic chk_outs(input logic [6:0] eo);
        chk("load_pc",     load_pc,     eo[6]);
        chk("load_if_id",  load_if_id,  eo[5]);
        chk("load_id_ex",  load_id_ex,  eo[4]);
        chk("load_ex_mem", load_ex_mem, eo[3]);
        chk("load_mem_wb", load_mem_wb, eo[2]);
        chk("flush_if_id", flush_if_id, eo[1]);
        chk("flush_id_ex", flush_id_ex, eo[0]);
    endtask

    task automatic chk_regs();
        chk("discarding", discarding, m_disc);
        chk("stall_cnt",  stall_cnt,  m_stall);
        chk("flush_cnt",  flush_cnt,  m_flush);
        chk("lu_cnt",     lu_cnt,     m_lu);
    endtask

    task automatic clr_in();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    endtask

    // Inputs are already driven (posedge+1); check combinational outputs at negedge,
    // advance the model at posedge, check registered state just after.
    task automatic step();
        int k;
        logic [6:0] eo;
        @(negedge clk);
        k  = kind_of();
        eo = exp_out(k);
        chk_outs(eo);
        @(posedge clk);
        if (k == 2 && imem_resp) m_disc = 0;
        if (k == 3 && imem_req && !imem_resp) m_disc = 1;
        if (k == 3) m_flush = sat(m_flush);
        if (k == 5) m_lu = sat(m_lu);
        if (k != 6 && !eo[6]) m_stall = sat(m_stall);
        #1;
        chk_regs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr_in();
        m_disc = 0; m_stall = 0; m_flush = 0; m_lu = 0;
        @(negedge clk);
        chk_outs(7'b0);
        @(posedge clk); #1;
        chk_regs();
        rst = 1'b1;
    endtask

    task automatic set_lu();
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1;
    endtask

    initial begin
        errs = 0; checks = 0;
        rst = 1'b0;
        clr_in();
        @(posedge clk); #1;
        do_reset();

        // Load-use: one bubble, then the load has moved on
        set_lu();
        step();
        chk("lu_once", lu_cnt, 1);
        clr_in();
        step();
        chk("after_lu_pc", load_pc, 1);
        set_lu(); ex_rd = 0; id_rs1 = 0;
        step();
        chk("x0_no_lu", lu_cnt, 1);

        // DMEM miss masks load-use for 4 cycles, bubble appears on the resp cycle
        do_reset();
        set_lu(); dmem_req = 1;
        repeat (4) step();
        chk("dmem_stall4", stall_cnt, 4);
        chk("dmem_lu0",    lu_cnt, 0);
        dmem_resp = 1;
        step();
        chk("dmem_lu1",    lu_cnt, 1);
        clr_in();

        // Redirect with fetch complete
        do_reset();
        ex_redirect = 1; imem_req = 1; imem_resp = 1;
        step();
        chk("redir_flush", flush_cnt, 1);
        chk("redir_run",   discarding, 0);
        clr_in();

        // Redirect with outstanding fetch: three discarding cycles
        do_reset();
        ex_redirect = 1; imem_req = 1; imem_resp = 0;
        step();
        ex_redirect = 0;
        repeat (2) step();
        imem_resp = 1;
        step();
        chk("disc_done", discarding, 0);
        imem_req = 1; imem_resp = 1;
        step();

        // Reset while discarding
        do_reset();
        ex_redirect = 1; imem_req = 1; imem_resp = 0;
        step();
        ex_redirect = 0;
        step();
        chk("pre_rst_disc", discarding, 1);
        rst = 1'b0;
        m_disc = 0; m_stall = 0; m_flush = 0; m_lu = 0;
        #1;
        chk_outs(7'b0);
        chk_regs();
        @(posedge clk); #1;
        rst = 1'b1;
        clr_in();
        step();
        chk("post_rst_pc", load_pc, 1);

        // Saturation with 4-bit counters
        do_reset();
        imem_req = 1;
        repeat (14) step();
        chk("sat_pre", stall_cnt, 14);
        repeat (3) step();
        chk("sat_hold", stall_cnt, 15);
        clr_in();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = ($urandom_range(0, 99) < 60);
            id_uses_rs2 = ($urandom_range(0, 99) < 40);
            ex_is_load  = ($urandom_range(0, 99) < 40);
            ex_redirect = ($urandom_range(0, 99) < 15);
            imem_req    = ($urandom_range(0, 99) < 60);
            imem_resp   = ($urandom_range(0, 99) < 50);
            dmem_req    = ($urandom_range(0, 99) < 20);
            dmem_resp   = ($urandom_range(0, 99) < 50);
            step();
            if (i == 300) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
